// File: rtl/mvm_gen_if.sv
// Command/data bundle for mvm_gen: load and start requests, element stream in,
// done pulse and result stream out.
`default_nettype none

interface mvm_gen_if #(
  parameter int B = 8
);
  logic                  loadMatrix;
  logic                  loadVector;
  logic                  start;
  logic                  accumulate;
  logic signed [B-1:0]   data_in;
  logic                  done;
  logic                  out_valid;
  logic signed [2*B-1:0] data_out;

  modport master (
    output loadMatrix, loadVector, start, accumulate, data_in,
    input  done, out_valid, data_out
  );

  modport slave (
    input  loadMatrix, loadVector, start, accumulate, data_in,
    output done, out_valid, data_out
  );
endinterface

`default_nettype wire

// File: rtl/mvm_gen.sv
// K x K matrix-vector multiplier with P MAC lanes, optional accumulate onto the previous result.
// Macro MVM_GEN_SAT_EN: results saturate to 2B bits; undefined: results wrap to 2B bits.
`default_nettype none

module mvm_gen #(
  parameter int K = 4,
  parameter int P = 1,
  parameter int B = 8,
  parameter int G = 0
) (
  input  logic       clk,
  input  logic       reset,
  mvm_gen_if.slave   bus
);

  localparam int KK    = K * K;
  localparam int NCOMP = K * (K / P);
  localparam int NDONE = NCOMP + 2 + G;
  localparam int W2    = 2 * B;
  localparam int SW    = W2 + $clog2(K) + 1;
  localparam int AW    = $clog2(KK);
  localparam int XW    = $clog2(K);
  localparam int CW    = $clog2(KK + NDONE + 1);

  localparam logic [CW-1:0] C_ONE    = CW'(1);
  localparam logic [CW-1:0] C_M_LAST = CW'(KK - 1);
  localparam logic [CW-1:0] C_K_LAST = CW'(K - 1);
  localparam logic [CW-1:0] C_ISSUE  = CW'(NCOMP);
  localparam logic [CW-1:0] C_DONE   = CW'(NDONE - 1);
  localparam logic [AW-1:0] C_AP     = AW'(P);
  localparam logic [XW-1:0] C_XP     = XW'(P);
  localparam logic [XW-1:0] C_XLAST  = XW'(K - P);
  localparam logic [XW-1:0] C_RONE   = XW'(1);

  typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_V, COMPUTE, OUTPUT} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  ov_q, ov_d;
  logic signed [W2-1:0]  dout_q, dout_d;

  logic signed [B-1:0]   a_mem [KK];
  logic signed [B-1:0]   x_mem [K];

  logic [AW-1:0]         ai_q;
  logic [XW-1:0]         xi_q, row_q;
  logic [P-1:0][W2-1:0]  w_prod, p1_q, w_p2;
  logic                  v1_q, w_v2;
  logic [XW-1:0]         r1_q, w_r2;
  logic signed [SW-1:0]  acc_q [K];
  logic signed [W2-1:0]  y_prev_q [K];
  logic signed [SW-1:0]  w_lsum, w_sel;
  logic signed [W2-1:0]  w_red;
  logic                  w_go, w_issue;

  assign w_go    = (state_q == IDLE) && bus.start && !bus.loadMatrix && !bus.loadVector;
  assign w_issue = (state_q == COMPUTE) && (cnt_q < C_ISSUE);

  // Row-major walk: the a index advances by P every issue cycle, x wraps every row.
  for (genvar p = 0; p < P; p++) begin : g_lane
    assign w_prod[p] = $signed(a_mem[ai_q + AW'(p)]) * $signed(x_mem[xi_q + XW'(p)]);
  end

  if (G != 0) begin : g_mul_pipe
    logic [P-1:0][W2-1:0] p2_q;
    logic                 v2_q;
    logic [XW-1:0]        r2_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        p2_q <= '0;
        v2_q <= 1'b0;
        r2_q <= '0;
      end else begin
        p2_q <= p1_q;
        v2_q <= v1_q;
        r2_q <= r1_q;
      end
    end
    assign w_p2 = p2_q;
    assign w_v2 = v2_q;
    assign w_r2 = r2_q;
  end else begin : g_no_mul_pipe
    assign w_p2 = p1_q;
    assign w_v2 = v1_q;
    assign w_r2 = r1_q;
  end

  always_comb begin
    w_lsum = '0;
    for (int p = 0; p < P; p++) begin
      w_lsum = w_lsum + SW'($signed(w_p2[p]));
    end
  end

  assign w_sel = acc_q[cnt_q[XW-1:0]];

`ifdef MVM_GEN_SAT_EN
  localparam logic signed [SW-1:0] C_SMAX = {{(SW-W2+1){1'b0}}, {(W2-1){1'b1}}};
  localparam logic signed [SW-1:0] C_SMIN = {{(SW-W2+1){1'b1}}, {(W2-1){1'b0}}};
  always_comb begin
    w_red = w_sel[W2-1:0];
    if (w_sel > C_SMAX) begin
      w_red = C_SMAX[W2-1:0];
    end else if (w_sel < C_SMIN) begin
      w_red = C_SMIN[W2-1:0];
    end
  end
`else
  logic w_unused_hi;
  assign w_red       = w_sel[W2-1:0];
  assign w_unused_hi = ^w_sel[SW-1:W2];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ov_d    = 1'b0;
    dout_d  = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.loadMatrix)      state_d = LOAD_M;
        else if (bus.loadVector) state_d = LOAD_V;
        else if (bus.start)      state_d = COMPUTE;
      end
      LOAD_M: begin
        cnt_d = cnt_q + C_ONE;
        if (cnt_q == C_M_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      LOAD_V: begin
        cnt_d = cnt_q + C_ONE;
        if (cnt_q == C_K_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      COMPUTE: begin
        cnt_d = cnt_q + C_ONE;
        if (cnt_q == C_DONE) begin
          state_d = OUTPUT;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      OUTPUT: begin
        ov_d   = 1'b1;
        dout_d = w_red;
        cnt_d  = cnt_q + C_ONE;
        if (cnt_q == C_K_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ov_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ov_q    <= ov_d;
      dout_q  <= dout_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ai_q  <= '0;
      xi_q  <= '0;
      row_q <= '0;
      p1_q  <= '0;
      v1_q  <= 1'b0;
      r1_q  <= '0;
      for (int i = 0; i < K; i++) begin
        acc_q[i]    <= '0;
        y_prev_q[i] <= '0;
      end
    end else begin
      p1_q <= w_prod;
      v1_q <= w_issue;
      r1_q <= row_q;
      if (w_go) begin
        ai_q  <= '0;
        xi_q  <= '0;
        row_q <= '0;
        for (int i = 0; i < K; i++) begin
          acc_q[i] <= bus.accumulate ? SW'(y_prev_q[i]) : '0;
        end
      end else begin
        if (w_issue) begin
          ai_q <= ai_q + C_AP;
          if (xi_q == C_XLAST) begin
            xi_q  <= '0;
            row_q <= row_q + C_RONE;
          end else begin
            xi_q <= xi_q + C_XP;
          end
        end
        if (w_v2) begin
          acc_q[w_r2] <= acc_q[w_r2] + w_lsum;
        end
      end
      if (state_q == OUTPUT) begin
        y_prev_q[cnt_q[XW-1:0]] <= w_red;
      end
    end
  end

  // Element storage deliberately survives reset.
  always_ff @(posedge clk) begin
    if (state_q == LOAD_M) a_mem[cnt_q[AW-1:0]] <= bus.data_in;
    if (state_q == LOAD_V) x_mem[cnt_q[XW-1:0]] <= bus.data_in;
  end

  assign bus.done      = done_q;
  assign bus.out_valid = ov_q;
  assign bus.data_out  = dout_q;

endmodule

`default_nettype wire

// File: tb/tb_mvm_gen.sv
// Scoreboard bench for mvm_gen (K=4, P=2, B=8, G=1): directed scenarios plus a randomized regression.
`default_nettype none

module tb_mvm_gen;
  localparam int K = 4;
  localparam int P = 2;
  localparam int B = 8;
  localparam int G = 1;
  localparam int N = K * (K / P) + 2 + G;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mvm_gen_if #(.B(B)) bus ();

  mvm_gen #(.K(K), .P(P), .B(B), .G(G)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int     a_m [K*K];
  int     x_m [K];
  longint yp_m [K];
  longint exp_y [$];
  int     exp_done [$];
  int     n_cmp = 0;
  int     n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input longint act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got %0d, none expected (cycle %0d)", name, act, cyc);
  endtask

  function automatic longint reduce(input longint s);
    longint w;
`ifdef MVM_GEN_SAT_EN
    if (s > 32767) w = 32767;
    else if (s < -32768) w = -32768;
    else w = s;
`else
    w = s & 64'hFFFF;
    if (w >= 32768) w = w - 65536;
`endif
    return w;
  endfunction

  // Golden model: y = (acc ? y_prev : 0) + A*x, reduced to 16 bits.
  task automatic predict(input bit acc);
    for (int r = 0; r < K; r++) begin
      longint s;
      s = acc ? yp_m[r] : 0;
      for (int c = 0; c < K; c++) s += longint'(a_m[r*K+c]) * longint'(x_m[c]);
      yp_m[r] = reduce(s);
      exp_y.push_back(yp_m[r]);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.done) begin
        if (exp_done.size() == 0) flag("done_unexpected", cyc);
        else check("done_cycle", cyc, exp_done.pop_front());
      end
      if (bus.out_valid) begin
        if (exp_y.size() == 0) flag("y_unexpected", bus.data_out);
        else check("y_value", bus.data_out, exp_y.pop_front());
      end else begin
        check("idle_data_zero", bus.data_out, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cmds();
    bus.loadMatrix = 1'b0;
    bus.loadVector = 1'b0;
    bus.start      = 1'b0;
    bus.accumulate = 1'b0;
  endtask

  task automatic load_matrix(input bit with_start);
    bus.loadMatrix = 1'b1;
    bus.start      = with_start;
    tick();
    clear_cmds();
    for (int i = 0; i < K*K; i++) begin
      bus.data_in = 8'(a_m[i]);
      tick();
    end
  endtask

  task automatic load_vector();
    bus.loadVector = 1'b1;
    tick();
    clear_cmds();
    for (int i = 0; i < K; i++) begin
      bus.data_in = 8'(x_m[i]);
      tick();
    end
  endtask

  // mode 0: quiet, 1: loadVector held during the busy window, 2: random stray commands.
  task automatic run_start(input bit acc, input int mode);
    predict(acc);
    bus.start      = 1'b1;
    bus.accumulate = acc;
    tick();
    exp_done.push_back(cyc + N);
    clear_cmds();
    for (int i = 0; i < N + K; i++) begin
      if (mode == 1) begin
        bus.loadVector = 1'b1;
        bus.data_in    = 8'($urandom);
      end else if (mode == 2) begin
        bus.loadMatrix = ($urandom_range(0, 3) == 0);
        bus.loadVector = ($urandom_range(0, 3) == 0);
        bus.start      = ($urandom_range(0, 3) == 0);
        bus.accumulate = 1'($urandom_range(0, 1));
        bus.data_in    = 8'($urandom);
      end
      tick();
    end
    clear_cmds();
  endtask

  task automatic apply_reset_check(input string tag);
    reset = 1'b1;
    exp_y.delete();
    exp_done.delete();
    for (int i = 0; i < K; i++) yp_m[i] = 0;
    #1;
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_data_out"}, bus.data_out, 0);
    check({tag, "_done"}, bus.done, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    clear_cmds();
    bus.data_in = '0;
    for (int i = 0; i < K; i++) yp_m[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", bus.done, 0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_data_out", bus.data_out, 0);
    reset = 1'b0;

    // Identity matrix, then accumulate onto it.
    for (int i = 0; i < K*K; i++) a_m[i] = (i / K == i % K) ? 1 : 0;
    x_m = '{1, -2, 3, -4};
    load_matrix(1'b0);
    load_vector();
    run_start(1'b0, 0);
    run_start(1'b1, 0);

    // loadVector during compute must be ignored.
    run_start(1'b0, 1);

    // Reset once y[1] has been presented; storage survives, y_prev does not.
    predict(1'b0);
    bus.start = 1'b1;
    tick();
    exp_done.push_back(cyc + N);
    clear_cmds();
    repeat (N + 2) tick();
    @(negedge clk);
    #1;
    apply_reset_check("rst_mid_output");
    reset = 1'b0;
    run_start(1'b1, 0);

    // loadMatrix with start: matrix load only, then saturation/wrap corner.
    for (int i = 0; i < K*K; i++) a_m[i] = 127;
    load_matrix(1'b1);
    repeat (5) tick();
    for (int i = 0; i < K; i++) x_m[i] = 127;
    load_vector();
    run_start(1'b0, 0);

    // Randomized regression with one reset in the middle of a compute.
    for (int op = 0; op < 1000; op++) begin
      if (op == 500) begin
        predict(1'($urandom_range(0, 1)));
        bus.start = 1'b1;
        tick();
        exp_done.push_back(cyc + N);
        clear_cmds();
        repeat ($urandom_range(1, N + K - 1)) tick();
        apply_reset_check("rst_mid_run");
        reset = 1'b0;
      end
      case ($urandom_range(0, 9))
        0, 1: begin
          for (int i = 0; i < K*K; i++) a_m[i] = int'($urandom_range(0, 255)) - 128;
          load_matrix(1'b0);
        end
        2, 3: begin
          for (int i = 0; i < K; i++) x_m[i] = int'($urandom_range(0, 255)) - 128;
          load_vector();
        end
        default: run_start(1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? 2 : 0);
      endcase
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (N + K + 4) tick();
    check("pending_results", exp_y.size(), 0);
    check("pending_done", exp_done.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
